// File: rtl/carfield_pkg.sv
// Shared Carfield definitions used by the system watchdog: address window,
// register offsets and the kick key.
package carfield_pkg;

  localparam logic [31:0] SystemWdtBase = 32'h2000_7000;
  localparam logic [31:0] SystemWdtSize = 32'h0000_1000;

  localparam logic [31:0] WdtKickKey = 32'h5A5A_A5A5;

  typedef enum logic [4:0] {
    WDT_CTRL     = 5'h00,
    WDT_PRESC    = 5'h04,
    WDT_BARK_THR = 5'h08,
    WDT_BITE_THR = 5'h0C,
    WDT_COUNT    = 5'h10,
    WDT_KICK     = 5'h14,
    WDT_STATUS   = 5'h18
  } wdt_reg_off_e;

  typedef struct packed {
    logic irq_en;
    logic lock;
    logic en;
  } wdt_ctrl_t;

endpackage

// File: rtl/carfield_sys_wdt_core.sv
// Watchdog datapath: prescaler, saturating counter, threshold compares and
// the bark/bite status flags.
module carfield_sys_wdt_core
  import carfield_pkg::*;
#(
  parameter int unsigned CntWidth   = 32,
  parameter int unsigned PrescWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [PrescWidth-1:0] presc_i,
  input  logic [CntWidth-1:0]   bark_thr_i,
  input  logic [CntWidth-1:0]   bite_thr_i,
  input  logic                  kick_i,
  input  logic                  bark_clr_i,
  output logic [CntWidth-1:0]   count_o,
  output logic                  bark_o,
  output logic                  bite_o
);

  logic [PrescWidth-1:0] presc_cnt_q, presc_cnt_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  bark_q, bark_d;
  logic                  bite_q, bite_d;
  logic                  tick;

  assign tick = en_i && (presc_cnt_q == presc_i);

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    count_d     = count_q;
    if (kick_i) begin
      presc_cnt_d = '0;
      count_d     = '0;
    end else if (en_i) begin
      if (tick) begin
        presc_cnt_d = '0;
        if (count_q != '1) count_d = count_q + CntWidth'(1);
      end else begin
        presc_cnt_d = presc_cnt_q + PrescWidth'(1);
      end
    end
  end

  // A bark condition that still holds overrides a concurrent clear.
  always_comb begin
    bark_d = bark_q;
    if (bark_clr_i) bark_d = 1'b0;
    if (en_i && (count_q >= bark_thr_i)) bark_d = 1'b1;
    bite_d = bite_q | (en_i && (count_q >= bite_thr_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt_q <= '0;
      count_q     <= '0;
      bark_q      <= 1'b0;
      bite_q      <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      count_q     <= count_d;
      bark_q      <= bark_d;
      bite_q      <= bite_d;
    end
  end

  assign count_o = count_q;
  assign bark_o  = bark_q;
  assign bite_o  = bite_q;

endmodule

// File: rtl/carfield_apb_sys_wdt.sv
// APB system watchdog: zero-wait-state register decode and configuration
// registers in front of the watchdog core.
module carfield_apb_sys_wdt
  import carfield_pkg::*;
#(
  parameter int unsigned CntWidth     = 32,
  parameter int unsigned PrescWidth   = 16,
  parameter int unsigned ApbAddrWidth = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ApbAddrWidth-1:0] paddr_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [31:0]             pwdata_i,
  output logic [31:0]             prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic                    irq_o,
  output logic                    rst_req_o
);

  wdt_ctrl_t             ctrl_q, ctrl_d;
  logic [PrescWidth-1:0] presc_q, presc_d;
  logic [CntWidth-1:0]   bark_thr_q, bark_thr_d;
  logic [CntWidth-1:0]   bite_thr_q, bite_thr_d;
  logic [CntWidth-1:0]   count;
  logic                  bark, bite, kick, bark_clr;
  logic                  access, in_window;
  logic [4:0]            off;

  assign access    = psel_i & penable_i;
  assign off       = paddr_i[4:0];
  assign in_window = (paddr_i[ApbAddrWidth-1:5] == '0);
  assign pready_o  = 1'b1;

  // Errors suppress every state update, so each write path is gated by the
  // same branch that raises pslverr_o.
  always_comb begin
    ctrl_d     = ctrl_q;
    presc_d    = presc_q;
    bark_thr_d = bark_thr_q;
    bite_thr_d = bite_thr_q;
    kick       = 1'b0;
    bark_clr   = 1'b0;
    prdata_o   = '0;
    pslverr_o  = 1'b0;
    if (access) begin
      if (!in_window) begin
        pslverr_o = 1'b1;
      end else begin
        case (off)
          WDT_CTRL: begin
            if (!pwrite_i) prdata_o[2:0] = {ctrl_q.irq_en, ctrl_q.lock, ctrl_q.en};
            else if (ctrl_q.lock) pslverr_o = 1'b1;
            else begin
              ctrl_d.en     = pwdata_i[0];
              ctrl_d.lock   = pwdata_i[1];
              ctrl_d.irq_en = pwdata_i[2];
            end
          end
          WDT_PRESC: begin
            if (!pwrite_i) prdata_o[PrescWidth-1:0] = presc_q;
            else if (ctrl_q.lock) pslverr_o = 1'b1;
            else presc_d = pwdata_i[PrescWidth-1:0];
          end
          WDT_BARK_THR: begin
            if (!pwrite_i) prdata_o[CntWidth-1:0] = bark_thr_q;
            else if (ctrl_q.lock) pslverr_o = 1'b1;
            else bark_thr_d = pwdata_i[CntWidth-1:0];
          end
          WDT_BITE_THR: begin
            if (!pwrite_i) prdata_o[CntWidth-1:0] = bite_thr_q;
            else if (ctrl_q.lock) pslverr_o = 1'b1;
            else bite_thr_d = pwdata_i[CntWidth-1:0];
          end
          WDT_COUNT: begin
            if (pwrite_i) pslverr_o = 1'b1;
            else prdata_o[CntWidth-1:0] = count;
          end
          WDT_KICK: begin
            if (!pwrite_i || (pwdata_i != WdtKickKey)) pslverr_o = 1'b1;
            else kick = 1'b1;
          end
          WDT_STATUS: begin
            if (pwrite_i) bark_clr = pwdata_i[0];
            else prdata_o[1:0] = {bite, bark};
          end
          default: pslverr_o = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= '0;
      presc_q    <= '0;
      bark_thr_q <= '1;
      bite_thr_q <= '1;
    end else begin
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      bark_thr_q <= bark_thr_d;
      bite_thr_q <= bite_thr_d;
    end
  end

  carfield_sys_wdt_core #(
    .CntWidth  (CntWidth),
    .PrescWidth(PrescWidth)
  ) i_core (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (ctrl_q.en),
    .presc_i   (presc_q),
    .bark_thr_i(bark_thr_q),
    .bite_thr_i(bite_thr_q),
    .kick_i    (kick),
    .bark_clr_i(bark_clr),
    .count_o   (count),
    .bark_o    (bark),
    .bite_o    (bite)
  );

  assign irq_o     = bark & ctrl_q.irq_en;
  assign rst_req_o = bite;

endmodule
